decode_buffer: RTL and testbench

DECODE_BUFFER -- requirements
Module: decode_buffer

---
 rtl/decode_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_decode_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_buffer.sv
// Decoded-uop FIFO: RV32I/SYSTEM decode at enqueue, DEPTH-entry in-order buffer. Latency 1 cycle.
// Backpressure: in_ready_o drops when full (no pass-through); head holds while out_ready_i is low.
// Optional RV32M decode is enabled by defining DECODE_BUFFER_RV32M_EN.
package decode_buffer_pkg;
    // PC and immediate storage are sized for the widest legal XLEN; bits above XLEN read as zero.
    typedef logic [31:0] inst_t;
    typedef logic [63:0] pc_t;
    typedef logic [63:0] imm_t;
    typedef logic [3:0]  fu_func_t;

    typedef enum logic [2:0] {
        FU_NONE = 3'd0, FU_ALU = 3'd1, FU_BRU = 3'd2, FU_LSU = 3'd3, FU_MDU = 3'd4, FU_CSR = 3'd5
    } fu_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_ALI, OP_ALR, OP_SYS
    } fu_op_t;

    // fu_func is {alt, fun3}; alt selects SUB/SRA/SRAI.
    localparam fu_func_t FN_ADDI = 4'h0, FN_ADD = 4'h0, FN_SUB = 4'h8, FN_SRAI = 4'hD;
    localparam fu_func_t FN_MUL  = 4'h0, FN_MULH = 4'h1, FN_MULHSU = 4'h2, FN_MULHU = 4'h3;
    localparam fu_func_t FN_DIV  = 4'h4, FN_DIVU = 4'h5, FN_REM = 4'h6, FN_REMU = 4'h7;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        pc_t        pc;
        fu_t        fu;
        fu_op_t     fu_op;
        fu_func_t   fu_func;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        imm_t       imm;
        logic       rd_wen;
        logic       ebreak;
    } uop_info_t;
endpackage

module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  pc_t                      in_pc_i,
    input  inst_t                    in_inst_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output uop_info_t                out_uop_o,
    output logic                     out_illegal_o,
    output logic                     out_csr_wen_o,
    output logic                     out_ecall_o,
    output logic                     out_mret_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        uop_info_t uop;
        logic      illegal;
        logic      csr_wen;
        logic      ecall;
        logic      mret;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    imm_t        w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    pc_t         w_pc;
    logic        w_sh_zero, w_sh_alt, w_ill, w_wen, w_push, w_pop;
    entry_t      w_dec, w_head;

    assign w_opc = in_inst_i[6:0];
    assign w_f3  = in_inst_i[14:12];
    assign w_f7  = in_inst_i[31:25];
    assign w_rd  = in_inst_i[11:7];

    assign w_imm_i = {{52{in_inst_i[31]}}, in_inst_i[31:20]};
    assign w_imm_s = {{52{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
    assign w_imm_b = {{51{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7], in_inst_i[30:25],
                      in_inst_i[11:8], 1'b0};
    assign w_imm_u = {{32{in_inst_i[31]}}, in_inst_i[31:12], 12'b0};
    assign w_imm_j = {{43{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12], in_inst_i[20],
                      in_inst_i[30:21], 1'b0};

    // RV64 shift-immediates carry a 6-bit shamt, so bit 25 belongs to the shamt there.
    assign w_sh_zero = (XLEN == 64) ? (in_inst_i[31:26] == 6'b000000) : (w_f7 == 7'b0000000);
    assign w_sh_alt  = (XLEN == 64) ? (in_inst_i[31:26] == 6'b010000) : (w_f7 == 7'b0100000);
    assign w_pc      = (XLEN == 64) ? in_pc_i : {32'b0, in_pc_i[31:0]};

    always_comb begin
        w_dec   = '0;
        w_ill   = 1'b0;
        w_wen   = 1'b0;
        w_imm   = '0;
        w_dec.uop.rs1 = in_inst_i[19:15];
        w_dec.uop.rs2 = in_inst_i[24:20];
        case (w_opc)
            OPC_LUI: begin
                w_dec.uop.fu = FU_ALU; w_dec.uop.fu_op = OP_LUI; w_imm = w_imm_u; w_wen = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.uop.fu = FU_ALU; w_dec.uop.fu_op = OP_AUIPC; w_imm = w_imm_u; w_wen = 1'b1;
            end
            OPC_JAL: begin
                w_dec.uop.fu = FU_BRU; w_dec.uop.fu_op = OP_JAL; w_imm = w_imm_j; w_wen = 1'b1;
            end
            OPC_JALR: begin
                w_dec.uop.fu = FU_BRU; w_dec.uop.fu_op = OP_JALR; w_imm = w_imm_i; w_wen = 1'b1;
                w_ill = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_dec.uop.fu = FU_BRU; w_dec.uop.fu_op = OP_BR; w_imm = w_imm_b;
                w_dec.uop.fu_func = {1'b0, w_f3};
                w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OPC_LOAD: begin
                w_dec.uop.fu = FU_LSU; w_dec.uop.fu_op = OP_LD; w_imm = w_imm_i; w_wen = 1'b1;
                w_dec.uop.fu_func = {1'b0, w_f3};
                w_ill = (w_f3 == 3'b111) ||
                        ((XLEN != 64) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
            end
            OPC_STORE: begin
                w_dec.uop.fu = FU_LSU; w_dec.uop.fu_op = OP_ST; w_imm = w_imm_s;
                w_dec.uop.fu_func = {1'b0, w_f3};
                w_ill = w_f3[2] || ((XLEN != 64) && (w_f3 == 3'b011));
            end
            OPC_OPIMM: begin
                w_dec.uop.fu = FU_ALU; w_dec.uop.fu_op = OP_ALI; w_imm = w_imm_i; w_wen = 1'b1;
                w_dec.uop.fu_func = {1'b0, w_f3};
                if (w_f3 == 3'b001) begin
                    w_ill = !w_sh_zero;
                end else if (w_f3 == 3'b101) begin
                    w_ill = !(w_sh_zero || w_sh_alt);
                    w_dec.uop.fu_func = {in_inst_i[30], w_f3};
                end
            end
            OPC_OP: begin
                w_dec.uop.fu_op = OP_ALR; w_wen = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_dec.uop.fu = FU_ALU; w_dec.uop.fu_func = {1'b0, w_f3};
                end else if ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) begin
                    w_dec.uop.fu = FU_ALU; w_dec.uop.fu_func = {1'b1, w_f3};
`ifdef DECODE_BUFFER_RV32M_EN
                end else if (w_f7 == 7'b0000001) begin
                    w_dec.uop.fu = FU_MDU; w_dec.uop.fu_func = {1'b0, w_f3};
`endif
                end else begin
                    w_ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                w_dec.uop.fu = FU_CSR; w_dec.uop.fu_op = OP_SYS;
                if (w_f3 == 3'b000) begin
                    if (in_inst_i == 32'h0000_0073)      w_dec.ecall      = 1'b1;
                    else if (in_inst_i == 32'h0010_0073) w_dec.uop.ebreak = 1'b1;
                    else if (in_inst_i == 32'h3020_0073) w_dec.mret       = 1'b1;
                    else                                  w_ill            = 1'b1;
                end else if (w_f3 == 3'b100) begin
                    w_ill = 1'b1;
                end else begin
                    // CSR address rides in imm, zero-extended.
                    w_dec.csr_wen = 1'b1; w_wen = 1'b1;
                    w_dec.uop.fu_func = {1'b0, w_f3};
                    w_imm = {52'b0, in_inst_i[31:20]};
                end
            end
            default: w_ill = 1'b1;
        endcase
        w_dec.uop.pc     = w_pc;
        w_dec.uop.imm    = (XLEN == 64) ? w_imm : {32'b0, w_imm[31:0]};
        w_dec.uop.rd_wen = w_wen && (w_rd != 5'd0);
        w_dec.uop.rd     = w_dec.uop.rd_wen ? w_rd : 5'd0;
        if (w_ill) begin
            w_dec         = '0;
            w_dec.uop.pc  = w_pc;
            w_dec.illegal = 1'b1;
        end
    end

    assign in_ready_o  = (r_count < CW'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign count_o     = r_count;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    assign w_head        = r_mem[r_rptr];
    assign out_uop_o     = out_valid_o ? w_head.uop : '0;
    assign out_illegal_o = out_valid_o && w_head.illegal;
    assign out_csr_wen_o = out_valid_o && w_head.csr_wen;
    assign out_ecall_o   = out_valid_o && w_head.ecall;
    assign out_mret_o    = out_valid_o && w_head.mret;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is unreset; it is masked at the outputs while invalid.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= w_dec;
    end
endmodule

// File: tb/tb_decode_buffer.sv
// Directed checks for decode_buffer: decode table plus fill/drain, flush and async reset sequences.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_n_i, flush_i, in_valid_i, out_ready_i;
    logic      in_ready_o, out_valid_o;
    pc_t       in_pc_i;
    inst_t     in_inst_i;
    uop_info_t out_uop_o;
    logic      out_illegal_o, out_csr_wen_o, out_ecall_o, out_mret_o;
    logic [2:0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    decode_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_uop_o(out_uop_o),
        .out_illegal_o(out_illegal_o), .out_csr_wen_o(out_csr_wen_o),
        .out_ecall_o(out_ecall_o), .out_mret_o(out_mret_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic        ill;
        fu_t         fu;
        fu_op_t      op;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wen;
        logic [3:0]  fl;   // {csr_wen, ecall, mret, ebreak}
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic [31:0] inst, logic ill, fu_t fu, fu_op_t op, logic [3:0] func,
                                logic [4:0] rd, logic [31:0] imm, logic wen, logic [3:0] fl);
        vec_t v;
        v.inst = inst; v.ill = ill; v.fu = fu; v.op = op; v.func = func;
        v.rd = rd; v.imm = imm; v.wen = wen; v.fl = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi_rd(int k);
        logic [31:0] r;
        r = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
        return r;
    endfunction

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        check({tag, "_uop_zero"}, 64'(out_uop_o != '0), 64'd0);
        check({tag, "_flags_zero"},
              64'({out_illegal_o, out_csr_wen_o, out_ecall_o, out_mret_o}), 64'd0);
    endtask

    // Called at a negedge; pushes one instruction, checks the decoded head, then pops it.
    task automatic push_check(input int i);
        vec_t v;
        logic [63:0] pc;
        v = vecs[i];
        pc = 64'h8000_0000 + 64'(4 * i);
        in_valid_i = 1'b1; in_inst_i = v.inst; in_pc_i = pc;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check($sformatf("v%0d_valid", i), 64'(out_valid_o), 64'd1);
        check($sformatf("v%0d_count", i), 64'(count_o), 64'd1);
        check($sformatf("v%0d_illegal", i), 64'(out_illegal_o), 64'(v.ill));
        check($sformatf("v%0d_fu", i), 64'(out_uop_o.fu), 64'(v.fu));
        check($sformatf("v%0d_fu_op", i), 64'(out_uop_o.fu_op), 64'(v.op));
        check($sformatf("v%0d_fu_func", i), 64'(out_uop_o.fu_func), 64'(v.func));
        check($sformatf("v%0d_rd", i), 64'(out_uop_o.rd), 64'(v.rd));
        check($sformatf("v%0d_imm", i), out_uop_o.imm, {32'b0, v.imm});
        check($sformatf("v%0d_rd_wen", i), 64'(out_uop_o.rd_wen), 64'(v.wen));
        check($sformatf("v%0d_flags", i),
              64'({out_csr_wen_o, out_ecall_o, out_mret_o, out_uop_o.ebreak}), 64'(v.fl));
        check($sformatf("v%0d_pc", i), out_uop_o.pc, pc);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check_empty($sformatf("v%0d_after_pop", i));
    endtask

    initial begin
        vecs[0]  = mk(32'h0050_0093, 0, FU_ALU,  OP_ALI,   FN_ADDI, 5'd1, 32'd5,        1, 4'b0000);
`ifdef DECODE_BUFFER_RV32M_EN
        vecs[1]  = mk(32'h0220_80B3, 0, FU_MDU,  OP_ALR,   FN_MUL,  5'd1, 32'd0,        1, 4'b0000);
`else
        vecs[1]  = mk(32'h0220_80B3, 1, FU_NONE, OP_NONE,  4'h0,    5'd0, 32'd0,        0, 4'b0000);
`endif
        vecs[2]  = mk(32'h0010_0073, 0, FU_CSR,  OP_SYS,   4'h0,    5'd0, 32'd0,        0, 4'b0001);
        vecs[3]  = mk(32'h3020_0073, 0, FU_CSR,  OP_SYS,   4'h0,    5'd0, 32'd0,        0, 4'b0010);
        vecs[4]  = mk(32'hFFFF_FFFF, 1, FU_NONE, OP_NONE,  4'h0,    5'd0, 32'd0,        0, 4'b0000);
        vecs[5]  = mk(32'h0000_0073, 0, FU_CSR,  OP_SYS,   4'h0,    5'd0, 32'd0,        0, 4'b0100);
        vecs[6]  = mk(32'h1234_52B7, 0, FU_ALU,  OP_LUI,   4'h0,    5'd5, 32'h1234_5000, 1, 4'b0000);
        vecs[7]  = mk(32'hFE20_8EE3, 0, FU_BRU,  OP_BR,    4'h0,    5'd0, 32'hFFFF_FFFC, 0, 4'b0000);
        vecs[8]  = mk(32'hFE20_AC23, 0, FU_LSU,  OP_ST,    4'h2,    5'd0, 32'hFFFF_FFF8, 0, 4'b0000);
        vecs[9]  = mk(32'h4020_81B3, 0, FU_ALU,  OP_ALR,   FN_SUB,  5'd3, 32'd0,        1, 4'b0000);
        vecs[10] = mk(32'h2020_81B3, 1, FU_NONE, OP_NONE,  4'h0,    5'd0, 32'd0,        0, 4'b0000);
        vecs[11] = mk(32'h0000_0013, 0, FU_ALU,  OP_ALI,   FN_ADDI, 5'd0, 32'd0,        0, 4'b0000);
        vecs[12] = mk(32'h0080_00EF, 0, FU_BRU,  OP_JAL,   4'h0,    5'd1, 32'd8,        1, 4'b0000);
        vecs[13] = mk(32'h3001_10F3, 0, FU_CSR,  OP_SYS,   4'h1,    5'd1, 32'h300,      1, 4'b1000);
        vecs[14] = mk(32'h0001_3083, 1, FU_NONE, OP_NONE,  4'h0,    5'd0, 32'd0,        0, 4'b0000);
        vecs[15] = mk(32'h1050_0073, 1, FU_NONE, OP_NONE,  4'h0,    5'd0, 32'd0,        0, 4'b0000);
        vecs[16] = mk(32'h4030_D093, 0, FU_ALU,  OP_ALI,   FN_SRAI, 5'd1, 32'h403,      1, 4'b0000);
        vecs[17] = mk(32'hFFF0_0113, 0, FU_ALU,  OP_ALI,   FN_ADDI, 5'd2, 32'hFFFF_FFFF, 1, 4'b0000);

        rst_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_pc_i = '0; in_inst_i = '0;
        #1;
        check_empty("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        // First push lands on the first rising edge after reset release.
        for (int i = 0; i < 18; i++) push_check(i);

        // Fill to DEPTH with the consumer stalled; a fifth push must be refused.
        for (int k = 1; k <= 4; k++) begin
            in_valid_i = 1'b1; in_inst_i = addi_rd(k);
            @(negedge clk_i);
        end
        in_inst_i = addi_rd(5);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("full_count", 64'(count_o), 64'd4);
        check("full_in_ready", 64'(in_ready_o), 64'd0);
        check("full_head_held", 64'(out_uop_o.rd), 64'd1);
        out_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_rd", k), 64'(out_uop_o.rd), 64'(k));
            check($sformatf("drain%0d_imm", k), out_uop_o.imm, 64'(k));
            check($sformatf("drain%0d_count", k), 64'(count_o), 64'(5 - k));
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
        check_empty("drained");

        // Simultaneous push and pop at count 2.
        for (int k = 6; k <= 7; k++) begin
            in_valid_i = 1'b1; in_inst_i = addi_rd(k);
            @(negedge clk_i);
        end
        in_inst_i = addi_rd(8); out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check("pushpop_count", 64'(count_o), 64'd2);
        check("pushpop_head", 64'(out_uop_o.rd), 64'd7);
        // Flush wins over a concurrent push.
        in_inst_i = addi_rd(9); flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; in_valid_i = 1'b0;
        check_empty("flush");
        in_valid_i = 1'b1; in_inst_i = addi_rd(10);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("post_flush_head", 64'(out_uop_o.rd), 64'd10);
        check("post_flush_count", 64'(count_o), 64'd1);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;

        // Async reset between edges with three entries, illegal at the head.
        in_valid_i = 1'b1; in_inst_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        in_inst_i = addi_rd(12);
        @(negedge clk_i);
        in_inst_i = addi_rd(13);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("pre_rst_count", 64'(count_o), 64'd3);
        check("pre_rst_illegal", 64'(out_illegal_o), 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_empty("async_rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_empty("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
